// File: rtl/dvp_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dvp_frame_tx
//  Description : DVP (8-bit camera bus) video transmitter. Emits vsync, href
//                and one byte per clock, two bytes per RGB565 pixel (high byte
//                first). Pixels come from an external show-ahead source or
//                from an internal test-pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module dvp_frame_tx #(
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 2,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 4,
    parameter int BAR_W       = H_ACTIVE / 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_mode,
    input  logic [15:0] solid_color,
    output logic        pix_req,
    input  logic [15:0] pix_data,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    // Frame geometry in byte clocks and lines
    localparam int c_LINE      = 2 * H_ACTIVE + H_BLANK;
    localparam int c_FRAME     = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int c_HW        = (c_LINE  > 1) ? $clog2(c_LINE)  : 1;
    localparam int c_VW        = (c_FRAME > 1) ? $clog2(c_FRAME) : 1;
    localparam int c_BW        = (BAR_W   > 1) ? $clog2(BAR_W)   : 1;
    localparam int c_ACT_START = VSYNC_LINES + V_BACK;
    localparam int c_ACT_END   = c_ACT_START + V_ACTIVE;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;
    logic [1:0]      r_mode;
    logic [15:0]     r_solid;
    logic [c_BW-1:0] r_bar_px;
    logic [2:0]      r_bar_idx;
    logic [7:0]      r_hold_lo;
    logic            r_vsync;
    logic            r_href;
    logic [7:0]      r_data;
    logic            r_fs;
    logic            r_fd;

    logic            w_run;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_frame_first;
    logic            w_vsync;
    logic            w_act_line;
    logic            w_href;
    logic            w_fetch;
    logic [1:0]      w_mode;
    logic [15:0]     w_solid;
    logic [7:0]      w_x;
    logic [c_BW-1:0] w_bar_px;
    logic [2:0]      w_bar_idx;
    logic [15:0]     w_bar_color;
    logic [15:0]     w_pixel;

    // Counter-cycle decode of the raster position
    assign w_run         = (r_state == S_RUN);
    assign w_h_last      = (int'(r_h_cnt) == c_LINE - 1);
    assign w_v_last      = (int'(r_v_cnt) == c_FRAME - 1);
    assign w_frame_first = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_vsync       = w_run && (int'(r_v_cnt) < VSYNC_LINES);
    assign w_act_line    = (int'(r_v_cnt) >= c_ACT_START) && (int'(r_v_cnt) < c_ACT_END);
    assign w_href        = w_run && w_act_line && (int'(r_h_cnt) < 2 * H_ACTIVE);
    assign w_fetch       = w_href && !r_h_cnt[0];
    assign w_x           = 8'(r_h_cnt >> 1);

    // On the frame's first counter cycle the latch is being loaded, so use the live inputs
    assign w_mode  = w_frame_first ? pattern_mode : r_mode;
    assign w_solid = w_frame_first ? solid_color  : r_solid;

    // Bar counters restart at the first pixel of every line
    assign w_bar_px  = (r_h_cnt == '0) ? '0   : r_bar_px;
    assign w_bar_idx = (r_h_cnt == '0) ? 3'd0 : r_bar_idx;

    assign pix_req = w_fetch && (w_mode == 2'd0);

    // Colour-bar lookup
    always_comb begin
        w_bar_color = 16'h0000;
        case (w_bar_idx)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
    end

    // Pixel source select
    always_comb begin
        w_pixel = 16'h0000;
        case (w_mode)
            2'd0:    w_pixel = pix_data;
            2'd1:    w_pixel = w_bar_color;
            2'd2:    w_pixel = {w_x[7:3], w_x[7:2], w_x[7:3]};
            default: w_pixel = w_solid;
        endcase
    end

    // Run/idle FSM and raster counters; a frame always completes once started
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                    if (enable) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_h_last) begin
                        r_h_cnt <= '0;
                        if (w_v_last) begin
                            r_v_cnt <= '0;
                            if (!enable) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_v_cnt <= r_v_cnt + c_VW'(1);
                        end
                    end else begin
                        r_h_cnt <= r_h_cnt + c_HW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_h_cnt <= '0;
                    r_v_cnt <= '0;
                end
            endcase
        end
    end

    // Latch pattern selection at frame start so it is stable across the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= 2'd0;
            r_solid <= 16'h0000;
        end else if (w_frame_first) begin
            r_mode  <= pattern_mode;
            r_solid <= solid_color;
        end
    end

    // Bar position: pixel-within-bar counter and saturating bar index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bar_px  <= '0;
            r_bar_idx <= 3'd0;
        end else if (w_fetch) begin
            if (int'(w_bar_px) == BAR_W - 1) begin
                r_bar_px  <= '0;
                r_bar_idx <= (w_bar_idx == 3'd7) ? 3'd7 : w_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= w_bar_px + c_BW'(1);
                r_bar_idx <= w_bar_idx;
            end
        end
    end

    // Registered bus outputs, one clock behind the counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync   <= 1'b0;
            r_href    <= 1'b0;
            r_data    <= 8'h00;
            r_hold_lo <= 8'h00;
            r_fs      <= 1'b0;
            r_fd      <= 1'b0;
        end else begin
            r_vsync <= w_vsync;
            r_href  <= w_href;
            r_fs    <= w_frame_first;
            r_fd    <= w_run && w_h_last && w_v_last;
            if (w_fetch) begin
                r_data    <= w_pixel[15:8];
                r_hold_lo <= w_pixel[7:0];
            end else if (w_href) begin
                r_data <= r_hold_lo;
            end else begin
                r_data <= 8'h00;
            end
        end
    end

    assign dvp_vsync   = r_vsync;
    assign dvp_href    = r_href;
    assign dvp_data    = r_data;
    assign frame_start = r_fs;
    assign frame_done  = r_fd;
    assign busy        = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dvp_frame_tx
//  Description : Directed self-checking bench for dvp_frame_tx using small
//                frame geometry (LINE=20 clocks, FRAME=7 lines).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_mode;
    logic [15:0] solid_color;
    logic [15:0] pix_data;
    logic        pix_req;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_start;
    logic        frame_done;
    logic        busy;

    logic        g_enable;
    logic        g_pix_req;
    logic        g_vsync;
    logic        g_href;
    logic [7:0]  g_data;
    logic        g_fs;
    logic        g_fd;
    logic        g_busy;

    logic [15:0] src_idx;
    logic        src_clr;

    logic        cap_vs [0:399];
    logic        cap_hr [0:399];
    logic        cap_fs [0:399];
    logic        cap_fd [0:399];
    logic        cap_bz [0:399];
    logic        cap_rq [0:399];
    logic [7:0]  cap_dt [0:399];
    logic [7:0]  gd     [0:400];
    logic        gh     [0:400];
    logic [15:0] bars   [0:7];

    int n_tot = 0;
    int n_bad = 0;
    int a, b, c, d, e;

    always #5 clk = ~clk;

    dvp_frame_tx #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .pix_req(pix_req), .pix_data(pix_data),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
    );

    dvp_frame_tx #(
        .H_ACTIVE(64), .V_ACTIVE(4), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) u_dut_grad (
        .clk(clk), .rst(rst), .enable(g_enable),
        .pattern_mode(2'd2), .solid_color(16'h0000),
        .pix_req(g_pix_req), .pix_data(16'h0000),
        .dvp_vsync(g_vsync), .dvp_href(g_href), .dvp_data(g_data),
        .frame_start(g_fs), .frame_done(g_fd), .busy(g_busy)
    );

    // External show-ahead source: A000 + running pixel index
    always @(posedge clk) begin
        if (src_clr) src_idx <= 16'd0;
        else if (pix_req) src_idx <= src_idx + 16'd1;
    end
    assign pix_data = 16'hA000 + src_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record n output cycles; drop enable at drop_at, change solid_color at mid_at
    task automatic capture(input int n, input int drop_at, input int mid_at, input logic [15:0] mid_solid);
        for (int k = 0; k < n; k++) begin
            if (k == drop_at) enable = 1'b0;
            if (k == mid_at) solid_color = mid_solid;
            cap_vs[k] = dvp_vsync;
            cap_hr[k] = dvp_href;
            cap_fs[k] = frame_start;
            cap_fd[k] = frame_done;
            cap_bz[k] = busy;
            cap_rq[k] = pix_req;
            cap_dt[k] = dvp_data;
            tick();
        end
    endtask

    initial begin
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

        rst = 1'b1; enable = 1'b0; g_enable = 1'b0;
        pattern_mode = 2'd0; solid_color = 16'h0000; src_clr = 1'b1;
        repeat (3) tick();
        check("reset_outs", {dvp_vsync, dvp_href, dvp_data, frame_start, frame_done, busy, pix_req}, 0);

        // Colour bars, back-to-back frames, enable dropped mid second frame
        pattern_mode = 2'd1; enable = 1'b1; src_clr = 1'b0; rst = 1'b0;
        tick();
        capture(300, 210, -1, 16'h0000);
        a = 0; b = 0; c = 0; d = 0; e = 0;
        for (int k = 0; k <= 140; k++) begin
            a += int'(cap_vs[k]); b += int'(cap_fs[k]); c += int'(cap_hr[k]);
            d += int'(cap_fd[k]); e += int'(cap_rq[k]);
        end
        check("busy_c0", cap_bz[0], 1);
        check("vsync_c0", cap_vs[0], 0);
        check("vsync_cnt", a, 20);
        check("vsync_c1", cap_vs[1], 1);
        check("vsync_c20", cap_vs[20], 1);
        check("vsync_c21", cap_vs[21], 0);
        check("fs_cnt", b, 1);
        check("fs_c1", cap_fs[1], 1);
        check("href_cnt", c, 64);
        check("href_c40", cap_hr[40], 0);
        check("href_c41", cap_hr[41], 1);
        check("href_c56", cap_hr[56], 1);
        check("href_c57", cap_hr[57], 0);
        check("fd_cnt", d, 1);
        check("fd_c140", cap_fd[140], 1);
        check("req_bars", e, 0);
        for (int i = 0; i < 8; i++) begin
            check("bar_l0_hi", cap_dt[41 + 2 * i], bars[i][15:8]);
            check("bar_l0_lo", cap_dt[42 + 2 * i], bars[i][7:0]);
            check("bar_l3_hi", cap_dt[101 + 2 * i], bars[i][15:8]);
            check("bar_l3_lo", cap_dt[102 + 2 * i], bars[i][7:0]);
        end
        a = 0; b = 0; c = 0;
        for (int k = 0; k < 300; k++) begin
            if (!cap_hr[k] && cap_dt[k] != 8'h00) a++;
            if (k >= 2 && k != 141 && cap_fs[k]) b++;
            if (k >= 281) c += int'(cap_vs[k]);
        end
        check("data_zero_blank", a, 0);
        check("fs_c141", cap_fs[141], 1);
        check("fs_extra", b, 0);
        check("fd_c280", cap_fd[280], 1);
        check("busy_c279", cap_bz[279], 1);
        check("busy_c280", cap_bz[280], 0);
        check("vsync_after_idle", c, 0);
        d = 0;
        for (int k = 0; k < 280; k++) d += int'(cap_bz[k]);
        check("busy_cnt", d, 280);

        // Solid colour latched per frame; change mid-frame takes effect next frame
        pattern_mode = 2'd3; solid_color = 16'h1234; enable = 1'b1;
        tick();
        capture(300, 200, 70, 16'hFFFF);
        a = 0; b = 0; c = 0;
        for (int k = 0; k <= 140; k++)
            if (cap_hr[k] && cap_dt[k] != ((k % 2 == 1) ? 8'h12 : 8'h34)) a++;
        for (int k = 141; k <= 280; k++) begin
            if (cap_hr[k] && cap_dt[k] != 8'hFF) b++;
            c += int'(cap_hr[k]);
        end
        check("solid_f1_bytes", a, 0);
        check("solid_f2_bytes", b, 0);
        check("solid_f2_href", c, 64);
        check("solid_c41", cap_dt[41], 8'h12);
        check("solid_c42", cap_dt[42], 8'h34);
        check("solid_c116", cap_dt[116], 8'h34);
        check("solid_c181", cap_dt[181], 8'hFF);
        check("solid_c182", cap_dt[182], 8'hFF);

        // External source
        pattern_mode = 2'd0; src_clr = 1'b1;
        tick();
        src_clr = 1'b0; enable = 1'b1;
        tick();
        capture(141, 70, -1, 16'h0000);
        a = 0; b = 0;
        for (int k = 0; k <= 140; k++) begin
            a += int'(cap_rq[k]);
            if (cap_rq[k] != ((k / 20 >= 2) && (k / 20 <= 5) && (k % 20 < 16) && (k % 2 == 0))) b++;
        end
        check("ext_req_cnt", a, 32);
        check("ext_req_pos", b, 0);
        check("ext_c41", cap_dt[41], 8'hA0);
        check("ext_c42", cap_dt[42], 8'h00);
        check("ext_c44", cap_dt[44], 8'h01);
        check("ext_c56", cap_dt[56], 8'h07);
        check("ext_c62", cap_dt[62], 8'h08);
        check("ext_c116", cap_dt[116], 8'h1F);

        // Reset mid-frame, then restart
        pattern_mode = 2'd1; enable = 1'b1;
        tick();
        repeat (60) tick();
        rst = 1'b1;
        tick();
        check("midrst_outs", {dvp_vsync, dvp_href, frame_start, frame_done, busy, pix_req}, 0);
        check("midrst_data", dvp_data, 8'h00);
        rst = 1'b0;
        tick();
        check("restart_busy", busy, 1);
        check("restart_vs0", dvp_vsync, 0);
        tick();
        check("restart_fs", frame_start, 1);
        check("restart_vs1", dvp_vsync, 1);
        enable = 1'b0;
        repeat (150) tick();

        // Gray gradient on the wide-line instance
        g_enable = 1'b1;
        tick();
        for (int k = 0; k <= 400; k++) begin
            if (k == 10) g_enable = 1'b0;
            gd[k] = g_data;
            gh[k] = g_href;
            tick();
        end
        check("grad_href264", gh[264], 0);
        check("grad_href265", gh[265], 1);
        check("grad_x8_hi", gd[281], 8'h08);
        check("grad_x8_lo", gd[282], 8'h41);
        check("grad_x40_hi", gd[345], 8'h29);
        check("grad_x40_lo", gd[346], 8'h45);
        check("grad_x63_hi", gd[391], 8'h39);
        check("grad_x63_lo", gd[392], 8'hE7);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- DVP video transmitter: the source side of the 8-bit camera pixel bus that the cmos_8_16bit receiver consumes.
- Emits vsync, href and 8-bit data, one byte per clock, two bytes per RGB565 pixel, high byte first.
- Pixels come either from an upstream show-ahead source (frame buffer readback) or from an internal test pattern.
- Used as a sensor emulator for the SDRAM frame path and as a DVP output to downstream boards.

Parameters:
- H_ACTIVE, 480, active pixels per line (even, ≥8)
- V_ACTIVE, 272, active lines per frame
- H_BLANK, 64, clocks of href-low per line
- VSYNC_LINES, 2, lines with vsync high at frame start
- V_BACK, 8, lines between vsync fall and first active line
- V_FRONT, 4, lines after last active line
- BAR_W, H_ACTIVE/8, pixels per colour bar

Ports:
- clk  in  1  byte clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run frames while high
- pattern_mode  in  2  0 external, 1 colour bars, 2 gray gradient, 3 solid
- solid_color  in  16  RGB565 value for mode 3
- pix_req  out  1  external-mode pixel request
- pix_data  in  16  RGB565; must be valid in the same cycle as pix_req
- dvp_vsync  out  1  frame sync, active high
- dvp_href  out  1  data valid
- dvp_data  out  8  byte data
- frame_start  out  1  one-cycle pulse
- frame_done  out  1  one-cycle pulse
- busy  out  1  high while not IDLE

Behaviour:
- Reset: state IDLE; h_cnt=0, v_cnt=0; all outputs 0. Reset asserted mid-frame aborts the frame; outputs are 0 on the cycle after rst is sampled.
- Derived sizes: LINE = 2*H_ACTIVE + H_BLANK clocks; FRAME = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT lines.
- FSM:
  - IDLE→RUN when enable=1; h_cnt=v_cnt=0 on entry. busy=1 from that cycle.
  - RUN: h_cnt counts 0..LINE-1 then wraps and increments v_cnt.
  - Last count (v_cnt=FRAME-1, h_cnt=LINE-1): if enable=1, restart at 0,0 with no gap cycle; else go to IDLE.
  - enable falling mid-frame never truncates the frame.
- Counter-cycle decode; all outputs are registered, one clock after the counter state they describe:
  - vsync = (v_cnt < VSYNC_LINES).
  - act_line = v_cnt in [VSYNC_LINES+V_BACK, VSYNC_LINES+V_BACK+V_ACTIVE).
  - href = act_line && h_cnt < 2*H_ACTIVE.
  - x = h_cnt>>1.
- Pixel fetch on counter cycles where href=1 and h_cnt[0]=0:
  - Capture the pixel into a 16-bit hold register.
  - Output dvp_data = pixel[15:8] in the next cycle and pixel[7:0] in the cycle after.
  - dvp_data = 0 whenever href output is 0.
- pix_req is combinational, high exactly on fetch cycles, and only in mode 0. Exactly H_ACTIVE requests per active line, none elsewhere. There is no backpressure: the source must supply data.
- pattern_mode and solid_color are latched at frame start (v_cnt=0, h_cnt=0) and held for the whole frame.
- Patterns:
  - Bars use a pixel counter (no divider). Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. The bar index advances every BAR_W pixels, saturates at 7 and resets each line.
  - Gradient: pixel = {x[7:3], x[7:2], x[7:3]}.
  - Solid: pixel = the latched solid_color.
- frame_start: high on the output cycle where dvp_vsync first goes high, i.e. from counter 0,0.
- frame_done: high on the output cycle following counter FRAME-1, LINE-1, whether the FSM restarts or returns to IDLE.
- Widths: h_cnt and v_cnt are sized with $clog2 of LINE and FRAME. No overflow is possible.

Test Plan:
Small params for all scenarios: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives LINE=20 and FRAME=7 lines (140 clocks).
1. Reset release, enable=1, mode 1 → vsync high for clocks 1..20. frame_start at clock 1. href rises at clock 41 for 16 clocks per line, 4 lines. Bytes FF,FF,FF,E0,07,FF,… (one bar per pixel). frame_done at clock 140.
2. Mode 0, pix_data = 16'hA000 + pixel index → pix_req 8 pulses per active line at even h_cnt, 32 per frame. dvp_data A0,00,A0,01,… each one clock after capture.
3. Mode 3, solid_color=16'h1234; change solid_color to 16'hFFFF mid-frame → entire frame outputs 12,34 pairs. The next frame outputs FF,FF.
4. Enable held high → back-to-back frames: the second frame_start arrives exactly 140 clocks after the first, with no gap. Enable dropped at clock 70 → frame completes, busy=0 after clock 140, then no more vsync.
5. rst pulsed at clock 60 (mid active line) → next cycle all outputs 0 and state IDLE. With enable=1 the frame restarts from vsync with a fresh frame_start.
6. Mode 2, H_ACTIVE=64 → gradient x=40 gives pixel 16'h2945, bytes 29,45.
